// File: rtl/id_ex_pipe.sv
// ============================================================================
//  Module   : id_ex_pipe
//  Purpose  : ID/EX pipeline register with valid/ready handshake, RAW hazard
//             detection, EX/MEM/WB operand forwarding, flush and stall count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int PAYLOAD_WIDTH   = 64,
    parameter int STALL_CNT_WIDTH = 16,
    parameter bit FWD_EN          = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       id_valid_i,
    output logic                       id_ready_o,
    input  logic [ADDR_WIDTH-1:0]      id_rs1_i,
    input  logic [ADDR_WIDTH-1:0]      id_rs2_i,
    input  logic                       id_rs1_used_i,
    input  logic                       id_rs2_used_i,
    input  logic [DATA_WIDTH-1:0]      id_rdata_a_i,
    input  logic [DATA_WIDTH-1:0]      id_rdata_b_i,
    input  logic [ADDR_WIDTH-1:0]      id_rd_i,
    input  logic                       id_reg_we_i,
    input  logic                       id_is_load_i,
    input  logic [PAYLOAD_WIDTH-1:0]   id_payload_i,
    input  logic [DATA_WIDTH-1:0]      ex_alu_result_i,
    input  logic [ADDR_WIDTH-1:0]      mem_rd_i,
    input  logic                       mem_we_i,
    input  logic [DATA_WIDTH-1:0]      mem_wdata_i,
    input  logic [ADDR_WIDTH-1:0]      wb_rd_i,
    input  logic                       wb_we_i,
    input  logic [DATA_WIDTH-1:0]      wb_wdata_i,
    input  logic                       flush_i,
    output logic                       ex_valid_o,
    input  logic                       ex_ready_i,
    output logic [DATA_WIDTH-1:0]      ex_op_a_o,
    output logic [DATA_WIDTH-1:0]      ex_op_b_o,
    output logic [ADDR_WIDTH-1:0]      ex_rd_o,
    output logic                       ex_reg_we_o,
    output logic                       ex_is_load_o,
    output logic [PAYLOAD_WIDTH-1:0]   ex_payload_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    localparam logic [STALL_CNT_WIDTH-1:0] C_CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                       ex_valid_q, ex_valid_d;
    logic [DATA_WIDTH-1:0]      ex_op_a_q, ex_op_a_d;
    logic [DATA_WIDTH-1:0]      ex_op_b_q, ex_op_b_d;
    logic [ADDR_WIDTH-1:0]      ex_rd_q, ex_rd_d;
    logic                       ex_reg_we_q, ex_reg_we_d;
    logic                       ex_is_load_q, ex_is_load_d;
    logic [PAYLOAD_WIDTH-1:0]   ex_payload_q, ex_payload_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic                  w_ex_we;
    logic                  w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
    logic                  w_hazard, w_advance, w_ready;
    logic [DATA_WIDTH-1:0] w_op_a, w_op_b;

    function automatic logic src_match(input logic [ADDR_WIDTH-1:0] rs,
                                       input logic                  used,
                                       input logic [ADDR_WIDTH-1:0] rd,
                                       input logic                  we);
        return used && (rs != '0) && we && (rd == rs);
    endfunction

    // The instruction held here is the one currently in EX.
    assign w_ex_we = ex_valid_q & ex_reg_we_q;
    assign w_ex_a  = src_match(id_rs1_i, id_rs1_used_i, ex_rd_q, w_ex_we);
    assign w_ex_b  = src_match(id_rs2_i, id_rs2_used_i, ex_rd_q, w_ex_we);
    assign w_mem_a = src_match(id_rs1_i, id_rs1_used_i, mem_rd_i, mem_we_i);
    assign w_mem_b = src_match(id_rs2_i, id_rs2_used_i, mem_rd_i, mem_we_i);
    assign w_wb_a  = src_match(id_rs1_i, id_rs1_used_i, wb_rd_i, wb_we_i);
    assign w_wb_b  = src_match(id_rs2_i, id_rs2_used_i, wb_rd_i, wb_we_i);

    generate
        if (FWD_EN) begin : g_fwd
            assign w_hazard = id_valid_i & ex_valid_q & ex_is_load_q & (w_ex_a | w_ex_b);
            assign w_op_a   = w_ex_a  ? ex_alu_result_i :
                              w_mem_a ? mem_wdata_i     :
                              w_wb_a  ? wb_wdata_i      : id_rdata_a_i;
            assign w_op_b   = w_ex_b  ? ex_alu_result_i :
                              w_mem_b ? mem_wdata_i     :
                              w_wb_b  ? wb_wdata_i      : id_rdata_b_i;
        end else begin : g_nofwd
            assign w_hazard = id_valid_i & (w_ex_a | w_ex_b | w_mem_a | w_mem_b);
            assign w_op_a   = w_wb_a ? wb_wdata_i : id_rdata_a_i;
            assign w_op_b   = w_wb_b ? wb_wdata_i : id_rdata_b_i;
        end
    endgenerate

    assign w_advance  = ~ex_valid_q | ex_ready_i;
    assign w_ready    = flush_i | (w_advance & ~w_hazard);
    // Gated by reset so that every output reads zero while reset is held.
    assign id_ready_o = rst_ni & w_ready;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_a_d    = ex_op_a_q;
        ex_op_b_d    = ex_op_b_q;
        ex_rd_d      = ex_rd_q;
        ex_reg_we_d  = ex_reg_we_q;
        ex_is_load_d = ex_is_load_q;
        ex_payload_d = ex_payload_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (w_advance) begin
            if (w_hazard) begin
                ex_valid_d  = 1'b0;
                ex_reg_we_d = 1'b0;
            end else if (id_valid_i) begin
                ex_valid_d   = 1'b1;
                ex_op_a_d    = w_op_a;
                ex_op_b_d    = w_op_b;
                ex_rd_d      = id_rd_i;
                ex_reg_we_d  = id_reg_we_i;
                ex_is_load_d = id_is_load_i;
                ex_payload_d = id_payload_i;
            end else begin
                ex_valid_d = 1'b0;
            end
        end

        if (id_valid_i && !w_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_rd_q      <= '0;
            ex_reg_we_q  <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_payload_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_a_q    <= ex_op_a_d;
            ex_op_b_q    <= ex_op_b_d;
            ex_rd_q      <= ex_rd_d;
            ex_reg_we_q  <= ex_reg_we_d;
            ex_is_load_q <= ex_is_load_d;
            ex_payload_q <= ex_payload_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_op_a_o    = ex_op_a_q;
    assign ex_op_b_o    = ex_op_b_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_reg_we_o  = ex_reg_we_q;
    assign ex_is_load_o = ex_is_load_q;
    assign ex_payload_o = ex_payload_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

`default_nettype wire
